// File: rtl/video_mode_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : video_mode_sequencer_if
// Brief    : Button/frame/auto inputs and mode-select outputs of the sequencer.
// Revision : 1.0
// ============================================================================
interface video_mode_sequencer_if;
  logic       btn_in;
  logic       new_frame_in;
  logic       auto_en_in;
  logic [1:0] mode_out;
  logic       mode_pending_out;
  logic       mode_change_out;

  modport master (
    output btn_in, new_frame_in, auto_en_in,
    input  mode_out, mode_pending_out, mode_change_out
  );

  modport slave (
    input  btn_in, new_frame_in, auto_en_in,
    output mode_out, mode_pending_out, mode_change_out
  );
endinterface
`default_nettype wire

// File: rtl/video_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : video_mode_sequencer
// Brief    : Debounced button / auto-cycle mode select, committed on frame start.
// Revision : 1.0
// ============================================================================
module video_mode_sequencer #(
  parameter int         DEBOUNCE_CYCLES = 371250,
  parameter int         AUTO_FRAMES     = 120,
  parameter logic [3:0] MODE_MASK       = 4'b1111
) (
  input  wire logic             clk_pixel_in,
  input  wire logic             rst_n_in,
  video_mode_sequencer_if.slave bus
);
  localparam int             c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int             c_fc_w    = $clog2(AUTO_FRAMES + 1);
  localparam logic [3:0]     c_mask    = MODE_MASK | 4'b0001;
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_fc_w-1:0] c_fc_last = c_fc_w'(AUTO_FRAMES - 1);

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              stable_q, stable_d, press_q, press_d;
  logic [c_db_w-1:0] db_cnt_q, db_cnt_d;
  logic [c_fc_w-1:0] fc_q, fc_d;
  logic [1:0]        mode_q, mode_d, pmode_q, pmode_d;
  logic              pend_q, pend_d, chg_q, chg_d;
  logic [1:0]        w_base_mode, w_adv_mode;

  // Smallest enabled mode above m, wrapping; m itself if nothing else is enabled.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    logic [1:0] r;
    logic [1:0] cand;
    logic       found;
    r     = m;
    found = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cand = m + 2'(i);
      if (!found && c_mask[cand]) begin
        r     = cand;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    sync1_d  = bus.btn_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == c_db_last) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + c_db_w'(1);
      end
    end

    mode_d      = mode_q;
    pend_d      = pend_q;
    pmode_d     = pmode_q;
    fc_d        = fc_q;
    chg_d       = 1'b0;
    w_base_mode = 2'b00;
    w_adv_mode  = 2'b00;
    if (bus.new_frame_in) begin
      if (pend_q) begin
        mode_d = pmode_q;
        pend_d = 1'b0;
        fc_d   = '0;
        chg_d  = 1'b1;
      end else if (bus.auto_en_in) begin
        if (fc_q == c_fc_last) begin
          fc_d   = '0;
          mode_d = next_mode(mode_q);
          chg_d  = (mode_d != mode_q);
        end else begin
          fc_d = fc_q + c_fc_w'(1);
        end
      end
    end
    if (!bus.auto_en_in) fc_d = '0;

    // A press on a frame-pulse cycle builds on the freshly committed mode.
    if (press_q) begin
      w_base_mode = (pend_q && !bus.new_frame_in) ? pmode_q : mode_d;
      w_adv_mode  = next_mode(w_base_mode);
      if (w_adv_mode != w_base_mode) begin
        pmode_d = w_adv_mode;
        pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      db_cnt_q <= '0;
      fc_q     <= '0;
      mode_q   <= 2'b00;
      pmode_q  <= 2'b00;
      pend_q   <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
      fc_q     <= fc_d;
      mode_q   <= mode_d;
      pmode_q  <= pmode_d;
      pend_q   <= pend_d;
      chg_q    <= chg_d;
    end
  end

  assign bus.mode_out         = mode_q;
  assign bus.mode_pending_out = pend_q;
  assign bus.mode_change_out  = chg_q;
endmodule
`default_nettype wire

// File: tb/tb_video_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_mode_sequencer
// Brief    : Directed bench with a cycle model for two mask configurations.
// Revision : 1.0
// ============================================================================
module tb_video_mode_sequencer;
  localparam int DB = 4;
  localparam int AF = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn_v  = 2'b00;
  logic [1:0] auto_v = 2'b00;
  logic       nf     = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  video_mode_sequencer_if bus_a ();
  video_mode_sequencer_if bus_b ();

  assign bus_a.btn_in       = btn_v[0];
  assign bus_a.auto_en_in   = auto_v[0];
  assign bus_a.new_frame_in = nf;
  assign bus_b.btn_in       = btn_v[1];
  assign bus_b.auto_en_in   = auto_v[1];
  assign bus_b.new_frame_in = nf;

  video_mode_sequencer #(.DEBOUNCE_CYCLES(DB), .AUTO_FRAMES(AF), .MODE_MASK(4'b1111)) dut_a (
    .clk_pixel_in(clk), .rst_n_in(rst_n), .bus(bus_a));
  video_mode_sequencer #(.DEBOUNCE_CYCLES(DB), .AUTO_FRAMES(AF), .MODE_MASK(4'b1011)) dut_b (
    .clk_pixel_in(clk), .rst_n_in(rst_n), .bus(bus_b));

  logic [1:0] dut_mode [2];
  logic       dut_pend [2];
  logic       dut_chg  [2];
  assign dut_mode[0] = bus_a.mode_out;
  assign dut_pend[0] = bus_a.mode_pending_out;
  assign dut_chg[0]  = bus_a.mode_change_out;
  assign dut_mode[1] = bus_b.mode_out;
  assign dut_pend[1] = bus_b.mode_pending_out;
  assign dut_chg[1]  = bus_b.mode_change_out;

  // Model state: synchronizer stages, history of synchronized samples, outcome.
  logic          m_s1 [2], m_s2 [2], m_stable [2], m_press [2];
  logic [DB-1:0] m_hist [2];
  logic [1:0]    m_mode [2], m_pmode [2];
  logic          m_pend [2], m_chg [2];
  int            m_fc [2];

  function automatic logic [3:0] mask_of(input int i);
    return (i == 0) ? 4'b1111 : 4'b1011;
  endfunction

  function automatic logic [1:0] nxt(input logic [1:0] m, input logic [3:0] mask);
    logic [3:0] en;
    logic [1:0] r;
    logic       found;
    en    = mask | 4'b0001;
    r     = m;
    found = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      if (!found && en[(int'(m) + s) % 4]) begin
        r     = 2'((int'(m) + s) % 4);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_press[i] = 0;
      m_hist[i] = '0; m_mode[i] = 0; m_pmode[i] = 0;
      m_pend[i] = 0; m_chg[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    logic       old_s2, prs, flip;
    logic [1:0] base, nb;
    old_s2    = m_s2[i];
    m_s2[i]   = m_s1[i];
    m_s1[i]   = btn_v[i];
    m_hist[i] = {m_hist[i][DB-2:0], old_s2};
    // The level is accepted once the last DB synchronized samples all disagree.
    flip       = (m_hist[i] == {DB{~m_stable[i]}});
    prs        = m_press[i];
    m_press[i] = flip & ~m_stable[i];
    if (flip) m_stable[i] = ~m_stable[i];
    m_chg[i] = 1'b0;
    if (nf) begin
      if (m_pend[i]) begin
        m_mode[i] = m_pmode[i]; m_pend[i] = 0; m_fc[i] = 0; m_chg[i] = 1;
      end else if (auto_v[i]) begin
        m_fc[i]++;
        if (m_fc[i] == AF) begin
          m_fc[i]   = 0;
          nb        = nxt(m_mode[i], mask_of(i));
          m_chg[i]  = (nb != m_mode[i]);
          m_mode[i] = nb;
        end
      end
    end
    if (!auto_v[i]) m_fc[i] = 0;
    if (prs) begin
      base = m_pend[i] ? m_pmode[i] : m_mode[i];
      nb   = nxt(base, mask_of(i));
      if (nb != base) begin
        m_pmode[i] = nb;
        m_pend[i]  = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cyc_mode%0d", i), 32'(dut_mode[i]), 32'(m_mode[i]));
        check($sformatf("cyc_pend%0d", i), 32'(dut_pend[i]), 32'(m_pend[i]));
        check($sformatf("cyc_chg%0d", i),  32'(dut_chg[i]),  32'(m_chg[i]));
      end
    end
  end

  task automatic expect_state(input string tag, input int i, input logic [1:0] mode,
                              input logic pend, input logic chg);
    check({tag, "_mode"}, 32'(dut_mode[i]), 32'(mode));
    check({tag, "_pend"}, 32'(dut_pend[i]), 32'(pend));
    check({tag, "_chg"},  32'(dut_chg[i]),  32'(chg));
    check({tag, "_model_mode"}, 32'(m_mode[i]), 32'(mode));
    check({tag, "_model_pend"}, 32'(m_pend[i]), 32'(pend));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    nf = 1'b1;
    tick(1);
    nf = 1'b0;
  endtask

  task automatic frame_gap();
    tick(49);
    frame();
  endtask

  task automatic press(input int i);
    btn_v[i] = 1'b1;
    tick(10);
    btn_v[i] = 1'b0;
    tick(10);
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);
    expect_state("reset_a", 0, 2'd0, 1'b0, 1'b0);
    expect_state("reset_b", 1, 2'd0, 1'b0, 1'b0);

    // Bouncing button: never stable for DB cycles, then a clean hold.
    for (int k = 0; k < 5; k++) begin
      btn_v[0] = 1'b1; tick(2);
      btn_v[0] = 1'b0; tick(2);
    end
    expect_state("bounce_none", 0, 2'd0, 1'b0, 1'b0);
    btn_v[0] = 1'b1; tick(10);
    expect_state("debounce_press", 0, 2'd0, 1'b1, 1'b0);
    btn_v[0] = 1'b0; tick(30);
    frame();
    expect_state("debounce_commit", 0, 2'd1, 1'b0, 1'b1);
    tick(1);
    expect_state("change_clears", 0, 2'd1, 1'b0, 1'b0);

    // Asynchronous reset with a request outstanding.
    press(0);
    frame();
    press(0);
    expect_state("pre_reset", 0, 2'd2, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_state("async_reset", 0, 2'd0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    frame();
    expect_state("post_reset_frame", 0, 2'd0, 1'b0, 1'b0);

    // Three presses inside one frame accumulate.
    press(0); press(0); press(0);
    expect_state("accum_wait", 0, 2'd0, 1'b1, 1'b0);
    frame();
    expect_state("accum_commit", 0, 2'd3, 1'b0, 1'b1);

    // Pending to 2, then a press event coinciding with the frame pulse.
    press(0); press(0); press(0);
    expect_state("sim_pre", 0, 2'd3, 1'b1, 1'b0);
    btn_v[0] = 1'b1;
    tick(6);
    nf = 1'b1;
    tick(1);
    nf = 1'b0;
    expect_state("sim_commit", 0, 2'd2, 1'b1, 1'b1);
    btn_v[0] = 1'b0;
    tick(20);
    frame();
    expect_state("sim_followup", 0, 2'd3, 1'b0, 1'b1);

    // Auto-cycling every AF frames, with a restart when disabled mid-count.
    auto_v[0] = 1'b1;
    frame_gap(); frame_gap();
    expect_state("auto_hold", 0, 2'd3, 1'b0, 1'b0);
    frame_gap();
    expect_state("auto_wrap", 0, 2'd0, 1'b0, 1'b1);
    frame_gap(); frame_gap(); frame_gap();
    expect_state("auto_step", 0, 2'd1, 1'b0, 1'b1);
    frame_gap();
    auto_v[0] = 1'b0;
    tick(5);
    auto_v[0] = 1'b1;
    frame_gap(); frame_gap();
    expect_state("auto_restart_hold", 0, 2'd1, 1'b0, 1'b0);
    frame_gap();
    expect_state("auto_restart_adv", 0, 2'd2, 1'b0, 1'b1);
    auto_v[0] = 1'b0;

    // Mode 2 disabled on instance B.
    expect_state("mask_start", 1, 2'd0, 1'b0, 1'b0);
    press(1);
    frame();
    expect_state("mask_to1", 1, 2'd1, 1'b0, 1'b1);
    press(1);
    frame();
    expect_state("mask_skip2", 1, 2'd3, 1'b0, 1'b1);
    press(1);
    frame();
    expect_state("mask_wrap", 1, 2'd0, 1'b0, 1'b1);
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
